// File: rtl/store_buffer.sv
// Posted-write buffer: queues core stores in a small FIFO, drains them in order over a
// valid/ready write channel, and forwards the youngest matching buffered store to loads.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     memwrite,
   input  logic [31:0]              aluresult,
   input  logic [31:0]              writedata,
   output logic [31:0]              readdata,
   output logic                     stall,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   output logic [31:0]              mem_raddr,
   input  logic [31:0]              mem_rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;

   logic full, empty, enq, deq;
   logic [PW-1:0] fwd_idx;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign enq       = memwrite && !full;
   assign deq       = mem_valid && mem_ready;
   assign stall     = memwrite && full;
   assign mem_valid = !empty;
   assign mem_addr  = addr_q[rptr_q];
   assign mem_wdata = data_q[rptr_q];
   assign mem_raddr = aluresult;
   assign count     = count_q;

   always_comb begin
      wptr_d  = enq ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = deq ? rptr_q + PW'(1) : rptr_q;
      count_d = count_q;
      case ({enq, deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Walk occupied entries oldest to youngest so the last match (youngest) wins.
   always_comb begin
      readdata = mem_rdata;
      fwd_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rptr_q + PW'(i);
         if ((CW'(i) < count_q) && (addr_q[fwd_idx][31:2] == aluresult[31:2]))
            readdata = data_q[fwd_idx];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         if (enq) begin
            addr_q[wptr_q] <= aluresult;
            data_q[wptr_q] <= writedata;
         end
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a drain-order scoreboard.
module tb_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        memwrite;
   logic [31:0] aluresult;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        stall;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata;
   logic [$clog2(DEPTH):0] count;

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] exp_q[$];

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .aluresult (aluresult),
      .writedata (writedata),
      .readdata  (readdata),
      .stall     (stall),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: every accepted handshake must match the oldest outstanding store.
   always @(negedge clk) begin
      if (reset && mem_valid && mem_ready) begin
         if (exp_q.size() == 0)
            check("unexpected_drain", 64'(exp_q.size()), 64'd1);
         else
            check("drain_order", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
   end

   // Called just after a rising edge; returns just after the edge that enqueued the store.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d);
      int guard;
      memwrite  = 1'b1;
      aluresult = a;
      writedata = d;
      exp_q.push_back({a, d});
      @(negedge clk);
      guard = 0;
      while (stall && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("store_stall_timeout", 64'(stall), 64'd0);
      @(posedge clk);
      #1;
      memwrite = 1'b0;
   endtask

   task automatic wait_empty();
      int guard;
      guard = 0;
      while (count != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("drain_to_empty", 64'(count), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b0;
      memwrite  = 1'b1;
      aluresult = 32'h40;
      writedata = 32'h1234_5678;
      mem_ready = 1'b1;
      mem_rdata = 32'h0;

      // Reset held with activity on the inputs
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_valid", 64'(mem_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      @(posedge clk);
      #1;
      memwrite = 1'b0;
      reset    = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      check("post_rst_valid", 64'(mem_valid), 64'd0);
      @(posedge clk);
      #1;

      // Basic drain
      do_store(32'h100, 32'hAAAA_0001);
      check("enq_latency_valid", 64'(mem_valid), 64'd1);
      check("enq_latency_addr", 64'(mem_addr), 64'h100);
      do_store(32'h104, 32'hBBBB_0002);
      check("basic_count2", 64'(count), 64'd2);
      mem_ready = 1'b1;
      @(negedge clk);
      check("basic_head0", 64'(mem_addr), 64'h100);
      @(negedge clk);
      check("basic_head1", 64'(mem_addr), 64'h104);
      @(negedge clk);
      check("basic_count0", 64'(count), 64'd0);
      @(posedge clk);
      #1;
      mem_ready = 1'b0;

      // Full and stall
      for (int i = 0; i < DEPTH; i++) begin
         do_store(32'h1000 + 32'(i * 4), 32'hC000_0000 + 32'(i));
      end
      check("full_count", 64'(count), 64'(DEPTH));
      memwrite  = 1'b1;
      aluresult = 32'h2000;
      writedata = 32'hC000_00FF;
      exp_q.push_back({32'h2000, 32'hC000_00FF});
      @(negedge clk);
      check("full_stall", 64'(stall), 64'd1);
      check("full_count_held", 64'(count), 64'(DEPTH));
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      @(negedge clk);
      check("stall_indep_ready", 64'(stall), 64'd1);
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      @(negedge clk);
      check("stall_release", 64'(stall), 64'd0);
      @(posedge clk);
      #1;
      memwrite = 1'b0;
      check("refill_count", 64'(count), 64'(DEPTH));
      mem_ready = 1'b1;
      wait_empty();
      mem_ready = 1'b0;

      // Forwarding
      do_store(32'h200, 32'h1111_1111);
      do_store(32'h200, 32'h2222_2222);
      do_store(32'h204, 32'h3333_3333);
      mem_rdata = 32'hDEAD_BEEF;
      aluresult = 32'h202;
      #1;
      check("fwd_youngest", 64'(readdata), 64'h2222_2222);
      check("mem_raddr", 64'(mem_raddr), 64'h202);
      aluresult = 32'h300;
      #1;
      check("fwd_miss", 64'(readdata), 64'hDEAD_BEEF);
      aluresult = 32'h207;
      #1;
      check("fwd_other_word", 64'(readdata), 64'h3333_3333);
      mem_ready = 1'b1;
      aluresult = 32'h200;
      @(negedge clk);
      check("fwd_while_dequeue", 64'(readdata), 64'h2222_2222);
      wait_empty();
      mem_ready = 1'b0;

      // Simultaneous enqueue/dequeue across pointer wrap
      do_store(32'h3000, 32'h5000_0000);
      do_store(32'h3004, 32'h5000_0001);
      mem_ready = 1'b1;
      for (int i = 0; i < 2 * DEPTH; i++) begin
         do_store(32'h4000 + 32'(i * 4), 32'h6000_0000 + 32'(i));
         check("simul_count", 64'(count), 64'd2);
      end
      wait_empty();
      mem_ready = 1'b0;

      // Reset mid-drain
      do_store(32'h500, 32'h7000_0000);
      do_store(32'h504, 32'h7000_0001);
      do_store(32'h508, 32'h7000_0002);
      check("mid_count3", 64'(count), 64'd3);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("async_rst_valid", 64'(mem_valid), 64'd0);
      check("async_rst_count", 64'(count), 64'd0);
      exp_q.delete();
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("discarded_valid", 64'(mem_valid), 64'd0);
      end

      check("sb_left", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle RISC-V core's data port and a slower, handshaked data-memory bus. Stores from the core are queued in a DEPTH-entry FIFO and drained in order over a valid/ready write channel, so a store completes in one core cycle while memory is busy. Loads are answered combinationally: from the youngest matching buffered store if one exists, otherwise from the memory read port. The core is stalled only when it issues a store while the buffer is full.

## Interface
- DEPTH, 4, number of buffered stores; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserted while 0
- memwrite  in  1  core store request this cycle
- aluresult  in  32  core byte address (store or load); bits [1:0] ignored
- writedata  in  32  core store data
- readdata  out  32  load data returned to core
- stall  out  1  core must hold PC/instruction this cycle
- mem_valid  out  1  head entry presented on write channel
- mem_ready  in  1  memory accepts head entry
- mem_addr  out  32  head entry address
- mem_wdata  out  32  head entry data
- mem_raddr  out  32  memory read address, equals aluresult
- mem_rdata  in  32  memory read data, combinational w.r.t. mem_raddr
- count  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Storage: DEPTH entries of {addr[31:0], data[31:0]}; write pointer, read pointer, occupancy counter. Pointers wrap modulo DEPTH.
- full = (count == DEPTH); empty = (count == 0).
- Enqueue: memwrite && !full → entry[wptr] ← {aluresult, writedata}, wptr+1.
- stall = memwrite && full (combinational; independent of mem_ready). Stalled store enqueues in the first cycle full deasserts.
- Dequeue: mem_valid && mem_ready → rptr+1.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance; legal when full only if memwrite was not stalled, i.e. never enqueues into a full buffer.
- mem_valid = !empty; mem_addr/mem_wdata = entry[rptr]. Head stays stable while mem_valid && !mem_ready.
- Drain strictly in enqueue order; no coalescing or merging of same-address stores.
- Forwarding: compare aluresult[31:2] against addr[31:2] of every occupied entry; readdata = data of youngest match (nearest to wptr), else mem_rdata. An entry being dequeued in the current cycle still forwards.
- mem_raddr = aluresult always.
- Full-word stores only; no byte enables.

## Timing
- Reset (reset==0, asynchronous): count=0, wptr=rptr=0, all entries cleared to 0; hence mem_valid=0, mem_addr=0, mem_wdata=0, stall=0, count=0. Pending stores are discarded on reset mid-operation.
- Enqueue latency: store in cycle N appears on mem_valid/mem_addr/mem_wdata in cycle N+1 if buffer was empty.
- Throughput: one enqueue and one dequeue per cycle.
- Forwarding and readdata are same-cycle combinational; a store in cycle N forwards to a load in cycle N+1 onward.
- count updates at the clock edge following the enqueue/dequeue.

## Test plan
- Reset: hold reset=0 with memwrite=1, mem_ready=1 → mem_valid=0, count=0, stall=0, mem_addr=0; release, no entry appears.
- Basic drain: mem_ready=0, stores {0x100,0xAAAA0001}, {0x104,0xBBBB0002}; then mem_ready=1 → count reaches 2, mem_addr 0x100 then 0x104 on consecutive cycles, count returns to 0.
- Full/stall: DEPTH=4, mem_ready=0, five consecutive stores → stall=1 on fifth only, count=4; raise mem_ready for one cycle → fifth store enqueues next cycle, order preserved.
- Forwarding: buffer {0x200,0x11111111} then {0x200,0x22222222}, mem_ready=0; load 0x202 with mem_rdata=0xDEADBEEF → readdata=0x22222222; load 0x300 → readdata=0xDEADBEEF.
- Simultaneous: count=2, memwrite=1 with mem_valid&&mem_ready → count stays 2, wrap-around over 2·DEPTH stores yields correct FIFO order.
- Reset mid-drain: count=3, assert reset asynchronously between edges → mem_valid drops immediately, buffered data never issued.
